irq_controller: RTL and testbench

Parametrised interrupt controller between external interrupt sources and the MIPS core. It generalises the single-source rising-edge pulse into NUM_SRC sources. Each source has per-source enable and edge/level mode, plus fixed priority encoding, a pending register and a request/acknowledge/end-of-interrupt handshake with the core. It replaces the edge-detect logic in the CPU wrapper and drives the core's interrupt input.

---
 rtl/irq_pkg.sv | 19 +
 rtl/irq_prio_enc.sv | 25 ++
 rtl/irq_controller.sv | 162 ++++++++++++++++
 tb/tb_irq_controller.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt controller.
package irq_pkg;

    // Handshake FSM states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } irq_state_t;

    // Configuration register select.
    localparam logic CFG_SEL_EN   = 1'b0;
    localparam logic CFG_SEL_MODE = 1'b1;

    // Per-source trigger mode.
    localparam logic MODE_LEVEL = 1'b0;
    localparam logic MODE_EDGE  = 1'b1;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: the lowest set index wins.
module irq_prio_enc
    import irq_pkg::*;
#(
    parameter int NUM_SRC = 8,
    parameter int ID_W    = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] i_req,
    output logic               o_valid,
    output logic [ID_W-1:0]    o_id
);

    // Scan upward; the first set bit found is kept.
    always_comb begin
        o_valid = 1'b0;
        o_id    = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (i_req[i] && !o_valid) begin
                o_valid = 1'b1;
                o_id    = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: NUM_SRC sources with per-source enable and
// edge/level mode, fixed lowest-index priority, pending register and a
// request / acknowledge / end-of-interrupt handshake with the core.
// Optional build macro IRQ_SYNC_EN adds a 2-flop synchroniser per source.
module irq_controller
    import irq_pkg::*;
#(
    parameter int NUM_SRC = 8,
    parameter int ID_W    = $clog2(NUM_SRC)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic               cfg_we,
    input  logic               cfg_sel,
    input  logic [NUM_SRC-1:0] cfg_wdata,
    input  logic               int_ack,
    input  logic               int_eoi,
    output logic               interrupt,
    output logic [ID_W-1:0]    irq_id,
    output logic [NUM_SRC-1:0] pending,
    output logic               in_service
);

    logic [NUM_SRC-1:0] w_sync;
    logic [NUM_SRC-1:0] r_prev;
    logic [NUM_SRC-1:0] w_rise;
    logic [NUM_SRC-1:0] r_en;
    logic [NUM_SRC-1:0] r_mode;
    logic [NUM_SRC-1:0] r_pend_edge;
    logic [NUM_SRC-1:0] w_pend_edge_nxt;
    logic [NUM_SRC-1:0] w_ack_clr;
    logic [NUM_SRC-1:0] w_mode_clr;
    logic [NUM_SRC-1:0] w_pending;
    logic [NUM_SRC-1:0] w_eligible;
    logic               w_win_valid;
    logic [ID_W-1:0]    w_win_id;
    logic               w_accept;
    irq_state_t         r_state;
    irq_state_t         w_state_nxt;
    logic [ID_W-1:0]    r_id;
    logic [ID_W-1:0]    w_id_nxt;

`ifdef IRQ_SYNC_EN
    logic [NUM_SRC-1:0] r_sync_meta;
    logic [NUM_SRC-1:0] r_sync;

    // Two-flop synchroniser for asynchronous sources.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync_meta <= '0;
            r_sync      <= '0;
        end else begin
            r_sync_meta <= irq_src;
            r_sync      <= r_sync_meta;
        end
    end

    assign w_sync = r_sync;
`else
    assign w_sync = irq_src;
`endif

    // One-cycle delayed copy of the conditioned sources for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= '0;
        end else begin
            r_prev <= w_sync;
        end
    end

    assign w_rise = w_sync & ~r_prev;

    // Enable and mode registers, written through the configuration port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en   <= '0;
            r_mode <= '0;
        end else if (cfg_we) begin
            if (cfg_sel == CFG_SEL_MODE) begin
                r_mode <= cfg_wdata;
            end else begin
                r_en <= cfg_wdata;
            end
        end
    end

    // r_mode bits are 1 for MODE_EDGE, so r_mode doubles as the edge mask.
    assign w_mode_clr = (cfg_we && (cfg_sel == CFG_SEL_MODE)) ? (r_mode & ~cfg_wdata) : '0;
    assign w_accept   = (r_state == REQ) && int_ack;
    assign w_ack_clr  = (w_accept && (r_mode[r_id] == MODE_EDGE)) ? (NUM_SRC'(1) << r_id) : '0;

    // Set is OR-ed in after the acknowledge clear so a coincident new edge is kept.
    assign w_pend_edge_nxt = ((r_pend_edge & ~w_ack_clr) | (w_rise & r_mode)) & ~w_mode_clr;

    // Latched edge events.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_edge <= '0;
        end else begin
            r_pend_edge <= w_pend_edge_nxt;
        end
    end

    // Edge bits come from the latch, level bits follow the conditioned source.
    assign w_pending  = (r_mode & r_pend_edge) | (~r_mode & w_sync);
    assign w_eligible = w_pending & r_en;

    irq_prio_enc #(
        .NUM_SRC (NUM_SRC),
        .ID_W    (ID_W)
    ) u_prio_enc (
        .i_req   (w_eligible),
        .o_valid (w_win_valid),
        .o_id    (w_win_id)
    );

    // Handshake state and latched request id.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_id    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_id    <= w_id_nxt;
        end
    end

    // Next-state logic; the id only changes when leaving IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_id_nxt    = r_id;
        case (r_state)
            IDLE: begin
                if (w_win_valid) begin
                    w_state_nxt = REQ;
                    w_id_nxt    = w_win_id;
                end
            end
            REQ: begin
                if (int_ack) begin
                    w_state_nxt = SERVICE;
                end
            end
            SERVICE: begin
                if (int_eoi) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign interrupt  = (r_state == REQ);
    assign in_service = (r_state == SERVICE);
    assign irq_id     = r_id;
    assign pending    = w_pending;

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller (NUM_SRC = 8).
module tb_irq_controller;

    localparam int N = 8;
`ifdef IRQ_SYNC_EN
    localparam bit SYNC = 1'b1;
`else
    localparam bit SYNC = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] src = '0;
    logic         we = 1'b0;
    logic         sel = 1'b0;
    logic [N-1:0] wd = '0;
    logic         ack = 1'b0;
    logic         eoi = 1'b0;
    logic         interrupt;
    logic [2:0]   irq_id;
    logic [N-1:0] pending;
    logic         in_service;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    irq_controller #(
        .NUM_SRC (N)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .irq_src    (src),
        .cfg_we     (we),
        .cfg_sel    (sel),
        .cfg_wdata  (wd),
        .int_ack    (ack),
        .int_eoi    (eoi),
        .interrupt  (interrupt),
        .irq_id     (irq_id),
        .pending    (pending),
        .in_service (in_service)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // phase: 0 = waiting, 1 = requesting, 2 = being serviced
    int           m_phase;
    int           m_id;
    bit [N-1:0]   m_en, m_mode, m_latched, m_last, m_s1, m_s2;

    function automatic bit [N-1:0] m_seen(input bit [N-1:0] s);
        return SYNC ? m_s2 : s;
    endfunction

    function automatic bit [N-1:0] m_pend(input bit [N-1:0] seen);
        bit [N-1:0] p;
        for (int i = 0; i < N; i++) p[i] = m_mode[i] ? m_latched[i] : seen[i];
        return p;
    endfunction

    task automatic m_reset();
        m_phase = 0; m_id = 0;
        m_en = '0; m_mode = '0; m_latched = '0; m_last = '0; m_s1 = '0; m_s2 = '0;
    endtask

    task automatic m_edge(input bit [N-1:0] s, input bit w, input bit sl,
                          input bit [N-1:0] d, input bit a, input bit e);
        bit [N-1:0] seen;
        bit [N-1:0] p;
        int win;
        int served;
        seen = m_seen(s);
        p = m_pend(seen);
        win = -1;
        served = -1;
        for (int i = 0; i < N; i++) if (p[i] && m_en[i] && win < 0) win = i;
        if (m_phase == 0) begin
            if (win >= 0) begin m_phase = 1; m_id = win; end
        end else if (m_phase == 1) begin
            if (a) begin
                if (m_mode[m_id]) served = m_id;
                m_phase = 2;
            end
        end else if (e) begin
            m_phase = 0;
        end
        for (int i = 0; i < N; i++) begin
            if (i == served) m_latched[i] = 1'b0;
            if (seen[i] && !m_last[i] && m_mode[i]) m_latched[i] = 1'b1;
        end
        if (w) begin
            if (sl) begin
                for (int i = 0; i < N; i++) if (m_mode[i] && !d[i]) m_latched[i] = 1'b0;
                m_mode = d;
            end else begin
                m_en = d;
            end
        end
        m_last = seen;
        m_s2 = m_s1;
        m_s1 = s;
    endtask

    // One clock: model advances with the inputs seen at the edge, outputs checked 1 time unit later.
    task automatic step();
        logic [N-1:0] s, d;
        logic w, sl, a, e;
        s = src; d = wd; w = we; sl = sel; a = ack; e = eoi;
        @(posedge clk);
        m_edge(s, w, sl, d, a, e);
        #1;
        chk("model.interrupt", 32'(interrupt), 32'(m_phase == 1));
        chk("model.in_service", 32'(in_service), 32'(m_phase == 2));
        chk("model.irq_id", 32'(irq_id), 32'(m_id));
        chk("model.pending", 32'(pending), 32'(m_pend(m_seen(src))));
    endtask

    task automatic idle_inputs();
        src = '0; we = 1'b0; sel = 1'b0; wd = '0; ack = 1'b0; eoi = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        m_reset();
        #1;
        chk("reset.interrupt", 32'(interrupt), 32'd0);
        chk("reset.irq_id", 32'(irq_id), 32'd0);
        chk("reset.pending", 32'(pending), 32'd0);
        chk("reset.in_service", 32'(in_service), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [N-1:0] src;
        logic         we;
        logic         sel;
        logic [N-1:0] wd;
        logic         ack;
        logic         eoi;
        logic         e_int;
        logic [2:0]   e_id;
        logic [N-1:0] e_pend;
        logic         e_svc;
    } vec_t;

    vec_t tbl[47];

    initial begin
        int n;
        // src,  we, sel, wd, ack, eoi | int, id, pend, svc  (expected after the edge, unsynchronised sources)
        tbl[0]  = '{8'h00, 1, 0, 8'hFF, 0, 0, 0, 3'd0, 8'h00, 0}; // enable all
        tbl[1]  = '{8'h00, 1, 1, 8'hFF, 0, 0, 0, 3'd0, 8'h00, 0}; // all edge
        tbl[2]  = '{8'h20, 0, 0, 8'h00, 0, 0, 0, 3'd0, 8'h20, 0}; // rise src5
        tbl[3]  = '{8'h00, 0, 0, 8'h00, 0, 0, 1, 3'd5, 8'h20, 0};
        tbl[4]  = '{8'h00, 0, 0, 8'h00, 1, 0, 0, 3'd5, 8'h00, 1}; // ack clears
        tbl[5]  = '{8'h00, 0, 0, 8'h00, 0, 1, 0, 3'd5, 8'h00, 0}; // eoi
        tbl[6]  = '{8'h00, 0, 0, 8'h00, 0, 0, 0, 3'd5, 8'h00, 0};
        tbl[7]  = '{8'h44, 0, 0, 8'h00, 0, 0, 0, 3'd5, 8'h44, 0}; // src6 + src2
        tbl[8]  = '{8'h00, 0, 0, 8'h00, 0, 0, 1, 3'd2, 8'h44, 0}; // 2 wins
        tbl[9]  = '{8'h00, 0, 0, 8'h00, 1, 1, 0, 3'd2, 8'h40, 1}; // ack+eoi = ack
        tbl[10] = '{8'h00, 0, 0, 8'h00, 0, 1, 0, 3'd2, 8'h40, 0};
        tbl[11] = '{8'h00, 0, 0, 8'h00, 0, 0, 1, 3'd6, 8'h40, 0}; // 6 next
        tbl[12] = '{8'h00, 0, 0, 8'h00, 0, 1, 1, 3'd6, 8'h40, 0}; // eoi in REQ ignored
        tbl[13] = '{8'h00, 0, 0, 8'h00, 1, 0, 0, 3'd6, 8'h00, 1};
        tbl[14] = '{8'h00, 0, 0, 8'h00, 1, 0, 0, 3'd6, 8'h00, 1}; // ack in SERVICE ignored
        tbl[15] = '{8'h00, 0, 0, 8'h00, 0, 1, 0, 3'd6, 8'h00, 0};
        tbl[16] = '{8'h00, 1, 0, 8'h00, 0, 0, 0, 3'd6, 8'h00, 0}; // disable all
        tbl[17] = '{8'h02, 0, 0, 8'h00, 0, 0, 0, 3'd6, 8'h02, 0}; // masked edge latched
        tbl[18] = '{8'h00, 0, 0, 8'h00, 0, 0, 0, 3'd6, 8'h02, 0};
        tbl[19] = '{8'h00, 1, 0, 8'h02, 0, 0, 0, 3'd6, 8'h02, 0}; // enable bit 1
        tbl[20] = '{8'h00, 0, 0, 8'h00, 0, 0, 1, 3'd1, 8'h02, 0};
        tbl[21] = '{8'h00, 0, 0, 8'h00, 1, 0, 0, 3'd1, 8'h00, 1};
        tbl[22] = '{8'h00, 0, 0, 8'h00, 0, 1, 0, 3'd1, 8'h00, 0};
        tbl[23] = '{8'h00, 1, 0, 8'hFF, 0, 0, 0, 3'd1, 8'h00, 0};
        tbl[24] = '{8'h00, 1, 1, 8'hF7, 0, 0, 0, 3'd1, 8'h00, 0}; // src3 level
        tbl[25] = '{8'h08, 0, 0, 8'h00, 0, 0, 1, 3'd3, 8'h08, 0};
        tbl[26] = '{8'h08, 0, 0, 8'h00, 1, 0, 0, 3'd3, 8'h08, 1};
        tbl[27] = '{8'h08, 0, 0, 8'h00, 0, 1, 0, 3'd3, 8'h08, 0};
        tbl[28] = '{8'h08, 0, 0, 8'h00, 0, 0, 1, 3'd3, 8'h08, 0}; // re-request 2 edges after eoi
        tbl[29] = '{8'h00, 0, 0, 8'h00, 0, 0, 1, 3'd3, 8'h00, 0}; // drop held in REQ
        tbl[30] = '{8'h00, 0, 0, 8'h00, 1, 0, 0, 3'd3, 8'h00, 1};
        tbl[31] = '{8'h00, 0, 0, 8'h00, 0, 1, 0, 3'd3, 8'h00, 0};
        tbl[32] = '{8'h00, 0, 0, 8'h00, 0, 0, 0, 3'd3, 8'h00, 0};
        tbl[33] = '{8'h00, 1, 1, 8'hFF, 0, 0, 0, 3'd3, 8'h00, 0}; // all edge
        tbl[34] = '{8'h10, 0, 0, 8'h00, 0, 0, 0, 3'd3, 8'h10, 0};
        tbl[35] = '{8'h00, 0, 0, 8'h00, 0, 0, 1, 3'd4, 8'h10, 0};
        tbl[36] = '{8'h10, 0, 0, 8'h00, 1, 0, 0, 3'd4, 8'h10, 1}; // rise on ack edge: set wins
        tbl[37] = '{8'h00, 0, 0, 8'h00, 0, 1, 0, 3'd4, 8'h10, 0};
        tbl[38] = '{8'h00, 0, 0, 8'h00, 0, 0, 1, 3'd4, 8'h10, 0};
        tbl[39] = '{8'h00, 0, 0, 8'h00, 1, 0, 0, 3'd4, 8'h00, 1};
        tbl[40] = '{8'h00, 0, 0, 8'h00, 0, 1, 0, 3'd4, 8'h00, 0};
        tbl[41] = '{8'h01, 0, 0, 8'h00, 0, 0, 0, 3'd4, 8'h01, 0};
        tbl[42] = '{8'h00, 1, 1, 8'hFE, 0, 0, 1, 3'd0, 8'h00, 0}; // edge->level clears
        tbl[43] = '{8'h00, 0, 0, 8'h00, 1, 0, 0, 3'd0, 8'h00, 1};
        tbl[44] = '{8'h00, 0, 0, 8'h00, 0, 1, 0, 3'd0, 8'h00, 0};
        tbl[45] = '{8'h00, 1, 1, 8'hFF, 0, 0, 0, 3'd0, 8'h00, 0}; // back to edge: nothing stale
        tbl[46] = '{8'h00, 0, 0, 8'h00, 0, 0, 0, 3'd0, 8'h00, 0};

        m_reset();
        do_reset();

        // Table phase
        for (int k = 0; k < 47; k++) begin
            src = tbl[k].src; we = tbl[k].we; sel = tbl[k].sel; wd = tbl[k].wd;
            ack = tbl[k].ack; eoi = tbl[k].eoi;
            step();
`ifndef IRQ_SYNC_EN
            chk($sformatf("tbl[%0d].interrupt", k), 32'(interrupt), 32'(tbl[k].e_int));
            chk($sformatf("tbl[%0d].irq_id", k), 32'(irq_id), 32'(tbl[k].e_id));
            chk($sformatf("tbl[%0d].pending", k), 32'(pending), 32'(tbl[k].e_pend));
            chk($sformatf("tbl[%0d].in_service", k), 32'(in_service), 32'(tbl[k].e_svc));
`endif
        end
        idle_inputs();

        // Latency of a single edge pulse on src5
        do_reset();
        we = 1'b1; sel = 1'b0; wd = 8'hFF; step();
        sel = 1'b1; step();
        idle_inputs();
        src = 8'h20; step();
        src = '0;
        n = 1;
        while (!interrupt && n < 12) begin
            step();
            n++;
        end
        chk("latency.edges", 32'(n), SYNC ? 32'd4 : 32'd2);
        chk("latency.irq_id", 32'(irq_id), 32'd5);
        ack = 1'b1; step(); ack = 1'b0;
        chk("ack.pending5", 32'(pending[5]), 32'd0);
        chk("ack.in_service", 32'(in_service), 32'd1);
        eoi = 1'b1; step(); eoi = 1'b0;
        step();
        chk("eoi.interrupt", 32'(interrupt), 32'd0);

        // Reset while in SERVICE
        src = 8'h01; step(); src = '0;
        n = 0;
        while (!interrupt && n < 12) begin
            step();
            n++;
        end
        chk("midrst.req", 32'(interrupt), 32'd1);
        ack = 1'b1; step(); ack = 1'b0;
        chk("midrst.in_service", 32'(in_service), 32'd1);
        #2;
        rst_n = 1'b0;
        m_reset();
        #1;
        chk("midrst.interrupt", 32'(interrupt), 32'd0);
        chk("midrst.irq_id", 32'(irq_id), 32'd0);
        chk("midrst.pending", 32'(pending), 32'd0);
        chk("midrst.svc", 32'(in_service), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        src = 8'hFF;
        repeat (6) step();
        chk("midrst.enable_cleared", 32'(interrupt), 32'd0);
        idle_inputs();
        step();

        // Randomised phase against the model
        for (int c = 0; c < 3000; c++) begin
            src = src ^ (N'($urandom) & N'($urandom) & N'($urandom));
            we  = ($urandom_range(0, 15) == 0);
            sel = 1'($urandom);
            wd  = N'($urandom);
            ack = 1'($urandom);
            eoi = 1'($urandom);
            step();
        end
        idle_inputs();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
